tx_key_encoder: RTL

Parametrised successor to the keypad-to-UART character decoder. It samples a key code, maps it to an ASCII byte and issues a one-cycle go strobe to the UART transmit driver. Unlike the earlier block, it honours a tx_busy handshake, enforces a configurable inter-character gap, and handles a direct key change without release. It can optionally auto-repeat a held key. It sits between the keypad scanner and tx_driver.

---
 rtl/tx_key_encoder_if.sv | 10 +
 rtl/tx_key_encoder.sv | 110 +++++++++++
 2 files changed

// File: rtl/tx_key_encoder_if.sv
// tx_key_encoder_if: key-in / character-out bundle between the keypad scanner, encoder and tx driver.
interface tx_key_encoder_if #(parameter int KEY_W = 5) ();
  logic [KEY_W-1:0] data;
  logic             tx_busy;
  logic             go;
  logic [7:0]       tx_character;
  logic             active;
  modport master (input data, tx_busy, output go, tx_character, active);
  modport slave  (output data, tx_busy, input go, tx_character, active);
endinterface

// File: rtl/tx_key_encoder.sv
// tx_key_encoder: maps keypad codes to ASCII and strobes go toward the UART driver, honouring busy, gap and repeat.
module tx_key_encoder #(
  parameter int KEY_W         = 5,
  parameter int GAP_CYCLES    = 12,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input logic               clk,
  input logic               rst_n,
  tx_key_encoder_if.master  bus
);
  localparam int MAXP = (GAP_CYCLES > REPEAT_DELAY)
                        ? ((GAP_CYCLES > REPEAT_PERIOD) ? GAP_CYCLES : REPEAT_PERIOD)
                        : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam int CW = $clog2(MAXP) + 1;
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, HOLD} state_t;

  state_t           state, state_n;
  logic [KEY_W-1:0] key, key_n;
  logic [7:0]       char_q, char_n;
  logic             go_q, go_n;
  logic [CW-1:0]    gap_cnt, gap_n, rep_cnt, rep_n;
  logic             first_rep, first_n;

  // Any set bit above bit 4 forces a space regardless of the low code.
  function automatic logic [7:0] map(input logic [KEY_W-1:0] k);
    logic [KEY_W+4:0] w;
    logic [4:0]       lo;
    w  = {5'b0, k};
    lo = k[4:0];
    if (|w[KEY_W+4:5]) return 8'h20;
    return (lo == 5'd17)                 ? 8'h30 :
           (lo >= 5'd1  && lo <= 5'd9)   ? 8'h30 + {3'b0, lo} :
           (lo >= 5'd10 && lo <= 5'd13)  ? 8'h37 + {3'b0, lo} :
           (lo == 5'd16)                 ? 8'h2A :
           (lo == 5'd18)                 ? 8'h23 : 8'h20;
  endfunction

  always_comb begin
    state_n = state;
    key_n   = key;
    char_n  = char_q;
    go_n    = 1'b0;
    gap_n   = gap_cnt;
    rep_n   = rep_cnt;
    first_n = first_rep;
    unique case (state)
      IDLE: if (bus.data != '0) begin
        key_n   = bus.data;
        first_n = 1'b1;
        state_n = LOAD;
      end
      LOAD: begin
        char_n  = map(key);
        state_n = SEND;
      end
      SEND: if (!bus.tx_busy) begin
        go_n    = 1'b1;
        gap_n   = '0;
        state_n = GAP;
      end
      GAP: if (gap_cnt == GAP_LAST) begin
        rep_n   = '0;
        state_n = HOLD;
      end else gap_n = gap_cnt + 1'b1;
      HOLD: if (bus.data == '0) state_n = IDLE;
      else if (bus.data != key) begin
        key_n   = bus.data;
        first_n = 1'b1;
        state_n = LOAD;
      end else if (REPEAT_EN != 0) begin
        // Repeats resend the already-loaded character without a LOAD pass.
        if (rep_cnt == (first_rep ? DLY_LAST : PER_LAST)) begin
          first_n = 1'b0;
          state_n = SEND;
        end else rep_n = rep_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key       <= '0;
      char_q    <= 8'h20;
      go_q      <= 1'b0;
      gap_cnt   <= '0;
      rep_cnt   <= '0;
      first_rep <= 1'b0;
    end else begin
      state     <= state_n;
      key       <= key_n;
      char_q    <= char_n;
      go_q      <= go_n;
      gap_cnt   <= gap_n;
      rep_cnt   <= rep_n;
      first_rep <= first_n;
    end
  end

  assign bus.go           = go_q;
  assign bus.tx_character = char_q;
  assign bus.active       = (state != IDLE);
endmodule
